accum_seq_ctrl: RTL

- Initiator/controller for the channel accumulator.
- Accepts a valid/ready stream of per-channel partial sums and forwards one beat per cycle as an accumulate strobe with its data.
- After the configured channel count, it issues a single-cycle stop, captures the accumulator's registered total and presents it on a valid/ready output stream.
- Sits between the PE partial-sum stream and the accumulator; it guarantees the accumulator never sees rec and stop asserted together.

---
 rtl/accum_seq_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/accum_seq_ctrl.sv
// Sequencing controller for the channel accumulator: it forwards partial sums as rec
// strobes, flushes with a stop pulse and then hands the captured total downstream.
module accum_seq_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 7
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [CNT_WIDTH-1:0]  i_cfg_n_channel,
    input  logic                  i_abort,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic [DATA_WIDTH-1:0] o_acc_data,
    output logic                  o_rec_accum,
    output logic                  o_stop_accum,
    input  logic [DATA_WIDTH-1:0] i_acc_result,
    input  logic [6:0]            i_acc_cnt,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  o_cnt_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        DRAIN = 3'd2,
        STOP  = 3'd3,
        CAPT  = 3'd4,
        OUT   = 3'd5
    } state_t;

    localparam int CMP_WIDTH = (CNT_WIDTH > 7) ? CNT_WIDTH : 7;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   beat_cnt;
    logic [CNT_WIDTH-1:0]   beat_next;
    logic [CNT_WIDTH-1:0]   n_lat;
    logic                   aborting;
    logic                   handshake;
    logic [CMP_WIDTH-1:0]   acc_cnt_ext;
    logic [CMP_WIDTH-1:0]   n_ext;

    assign s_ready     = (state == ACCUM) && (beat_cnt != n_lat);
    assign handshake   = s_valid && s_ready;
    assign beat_next   = beat_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    assign acc_cnt_ext = CMP_WIDTH'(i_acc_cnt);
    assign n_ext       = CMP_WIDTH'(n_lat);

    // Strobes default low each cycle so rec and stop can only ever be set in disjoint states.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            n_lat        <= '0;
            aborting     <= 1'b0;
            o_acc_data   <= '0;
            o_rec_accum  <= 1'b0;
            o_stop_accum <= 1'b0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            o_cnt_err    <= 1'b0;
        end else begin
            o_rec_accum  <= 1'b0;
            o_stop_accum <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_cfg_n_channel != '0) begin
                        n_lat    <= i_cfg_n_channel;
                        beat_cnt <= '0;
                        aborting <= 1'b0;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (i_abort) begin
                        aborting     <= 1'b1;
                        o_stop_accum <= 1'b1;
                        state        <= STOP;
                    end else if (handshake) begin
                        o_acc_data  <= s_data;
                        o_rec_accum <= 1'b1;
                        beat_cnt    <= beat_next;
                        if (beat_next == n_lat) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    o_stop_accum <= 1'b1;
                    state        <= STOP;
                    if (i_abort) begin
                        aborting <= 1'b1;
                    end
                end
                // An aborted group only needed the flush; skip the count check and capture.
                STOP: begin
                    if (aborting) begin
                        aborting <= 1'b0;
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        if (acc_cnt_ext != n_ext) begin
                            o_cnt_err <= 1'b1;
                        end
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    m_data  <= i_acc_result;
                    m_valid <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid  <= 1'b0;
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
